// File: rtl/sha_pkg.sv
// Shared constants and FSM state encoding for the SHA-256 message-block path.
package sha_pkg;
  localparam int WORD_BITS   = 32;
  localparam int BLOCK_WORDS = 16;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;
endpackage

// File: rtl/mod_counter.sv
// Free-running up counter with synchronous clear; wraps naturally at 2^WIDTH.
module mod_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/sha_block_deserializer.sv
// Packs a stream of message words into one SHA-256 block (word 0 in the MSBs)
// and holds it in a single buffer until the scheduler takes it.
module sha_block_deserializer #(
  parameter int WORD_BITS = sha_pkg::WORD_BITS,
  parameter int WORDS     = sha_pkg::BLOCK_WORDS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WORD_BITS-1:0]       in_word,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WORD_BITS*WORDS-1:0] out_block,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WORDS)-1:0]   word_cnt
);
  import sha_pkg::*;

  localparam int CW = $clog2(WORDS);

  state_t               state;
  logic                 accept;
  logic                 last_word;
  logic [WORDS-1:0]     slot_we;
  logic [WORD_BITS-1:0] slot_q [WORDS];

  // Handshake outputs decode only from state, so no input reaches an output.
  assign in_ready  = (state == FILL);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;
  assign last_word = (word_cnt == CW'(WORDS - 1));

  // WORDS is a power of two, so the natural wrap returns word_cnt to 0
  // on the same edge that completes the block.
  mod_counter #(.WIDTH(CW)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept),
    .clr   (1'b0),
    .cnt   (word_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      case (state)
        FILL:    if (accept && last_word) state <= HOLD;
        HOLD:    if (out_ready)           state <= FILL;
        default:                          state <= FILL;
      endcase
    end
  end

  for (genvar k = 0; k < WORDS; k++) begin : g_slot
    assign slot_we[k] = accept && (word_cnt == CW'(k));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          slot_q[k] <= '0;
      else if (slot_we[k]) slot_q[k] <= in_word;
    end

    assign out_block[WORD_BITS*(WORDS-k)-1 -: WORD_BITS] = slot_q[k];
  end
endmodule

// File: tb/tb_sha_block_deserializer.sv
// Scoreboard bench: a word-level model builds expected blocks as words are
// accepted; a monitor pops and compares them when out_valid rises.
module tb_sha_block_deserializer;
  logic          clk;
  logic          rst_n;
  logic [31:0]   in_word;
  logic          in_valid;
  logic          in_ready;
  logic [511:0]  out_block;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    word_cnt;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [15:0][31:0] mblk;
  int                mcnt = 0;
  logic [511:0]      exp_q[$];
  logic [511:0]      held;
  logic              pv = 1'b0;

  sha_block_deserializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_word   (in_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_block (out_block),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Monitor: compare each new block against the scoreboard, then check it stays put.
  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (out_valid && !pv) begin
        if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
        else                   chk("block", out_block, exp_q.pop_front());
        held = out_block;
      end else if (out_valid) begin
        chk("hold_stable", out_block, held);
      end
      pv = out_valid;
    end
  end

  // Called at a negedge; returns at the negedge after the word is accepted,
  // leaving in_valid high so back-to-back calls keep the stream continuous.
  task automatic put_word(input logic [31:0] w, output int acc_cyc);
    int n = 0;
    in_valid = 1'b1;
    in_word  = w;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 1, 0);
      acc_cyc = cyc;
      return;
    end
    acc_cyc = cyc;
    mblk[15-mcnt] = w;
    mcnt++;
    if (mcnt == 16) begin
      exp_q.push_back(mblk);
      mcnt = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int t0, t1, tmp, gap;
    logic [31:0] w;
    rst_n = 1'b0; in_valid = 1'b0; in_word = '0; out_ready = 1'b1;
    #1;
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_block", out_block, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: back-to-back fill, consumer always ready
    for (int k = 0; k < 16; k++) put_word(32'(k), tmp);
    in_valid = 1'b0;
    chk("t1_valid_rise", out_valid, 1);
    chk("t1_slot0", out_block[511:480], 32'h0);
    chk("t1_slot15", out_block[31:0], 32'hF);
    @(negedge clk);
    chk("t1_valid_one_cycle", out_valid, 0);

    // 2: consumer stalls 5 cycles; a word offered during HOLD must be ignored
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) put_word(32'(k), tmp);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid_held", out_valid, 1);
      chk("t2_in_ready_low", in_ready, 0);
      in_valid = (i == 1);
      in_word  = 32'hDEADBEEF;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_released", out_valid, 0);
    chk("t2_word_cnt", word_cnt, 0);

    // 3: two blocks with in_valid continuously high
    for (int k = 0; k < 16; k++) begin
      put_word(32'h100 + 32'(k), tmp);
      if (k == 0) t0 = tmp;
    end
    for (int k = 0; k < 16; k++) put_word(32'h200 + 32'(k), tmp);
    in_valid = 1'b0;
    t1 = cyc;
    chk("t3_second_valid", out_valid, 1);
    chk("t3_second_slot0", out_block[511:480], 32'h200);
    chk("t3_span_cycles", 512'(t1 - t0 + 1), 512'd34);
    @(negedge clk);

    // 4: randomly gated source; word_cnt must track accepts only
    for (int k = 0; k < 16; k++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        idle();
        chk("t4_word_cnt_stall", word_cnt, mcnt);
      end
      put_word(32'hA5A50000 + 32'(k), tmp);
      in_valid = 1'b0;
      if (k < 15) chk("t4_word_cnt", word_cnt, mcnt);
    end
    @(negedge clk);

    // 5: reset mid-fill discards the partial block
    for (int k = 0; k < 7; k++) put_word(32'hBAD00000 + 32'(k), tmp);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_cnt", word_cnt, 0);
    chk("t5_async_valid", out_valid, 0);
    mcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) chk("t5_no_early_valid", out_valid, 0);
      put_word(32'hC0000000 + 32'(k), tmp);
    end
    in_valid = 1'b0;
    chk("t5_valid", out_valid, 1);
    chk("t5_slot0", out_block[511:480], 32'hC0000000);
    @(negedge clk);

    // 6: word offered in the same HOLD cycle that releases the block
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) put_word(32'h3000 + 32'(k), tmp);
    in_valid = 1'b0;
    @(negedge clk);
    w = 32'h5EED0001;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_word   = w;
    @(negedge clk);
    chk("t6_not_accepted_cnt", word_cnt, 0);
    chk("t6_back_in_fill", in_ready, 1);
    put_word(w, tmp);
    in_valid = 1'b0;
    chk("t6_word_cnt", word_cnt, 1);
    for (int k = 1; k < 16; k++) put_word(32'h6000 + 32'(k), tmp);
    in_valid = 1'b0;
    chk("t6_slot0", out_block[511:480], w);
    @(negedge clk); @(negedge clk);

    chk("queue_drained", 512'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
